// File: rtl/basic_computer_pkg.sv
// rtl/basic_computer_pkg.sv - shared widths, opcodes and IR field positions for the basic computer
package basic_computer_pkg;
    localparam int SC_W  = 3;
    localparam int OPC_W = 3;
    localparam int NUM_T = 1 << SC_W;

    localparam logic [OPC_W-1:0] OPC_AND = 3'd0;
    localparam logic [OPC_W-1:0] OPC_ADD = 3'd1;
    localparam logic [OPC_W-1:0] OPC_LDA = 3'd2;
    localparam logic [OPC_W-1:0] OPC_STA = 3'd3;
    localparam logic [OPC_W-1:0] OPC_BUN = 3'd4;
    localparam logic [OPC_W-1:0] OPC_BSA = 3'd5;
    localparam logic [OPC_W-1:0] OPC_ISZ = 3'd6;
    localparam logic [OPC_W-1:0] OPC_REG = 3'd7;

    localparam int IR_I      = 15;
    localparam int IR_OPC_HI = 14;
    localparam int IR_OPC_LO = 12;
    localparam int B_ION     = 7;
    localparam int B_IOF     = 6;

    function automatic logic [NUM_T-1:0] onehot(input logic [SC_W-1:0] v);
        return {{(NUM_T-1){1'b0}}, 1'b1} << v;
    endfunction
endpackage

// File: rtl/timing_sequencer_if.sv
// rtl/timing_sequencer_if.sv - control-decoder side bundle of the timing sequencer
interface timing_sequencer_if;
    import basic_computer_pkg::*;

    logic [15:0]      ir;
    logic             hlt;
    logic             start;
    logic             fgi;
    logic             fgo;
    logic [NUM_T-1:0] T;
    logic [2:0]       RT;
    logic [7:0]       D;
    logic             I;
    logic             In;
    logic             D7n;
    logic [11:0]      B;
    logic             ien;
    logic             halted;
    logic             sc_err;

    modport master (
        output ir, hlt, start, fgi, fgo,
        input  T, RT, D, I, In, D7n, B, ien, halted, sc_err
    );

    modport slave (
        input  ir, hlt, start, fgi, fgo,
        output T, RT, D, I, In, D7n, B, ien, halted, sc_err
    );
endinterface

// File: rtl/timing_sequencer_seq_counter.sv
// rtl/timing_sequencer_seq_counter.sv - sequence counter with clear/increment/hold and one-hot decode
module seq_counter
    import basic_computer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             hold,
    output logic [SC_W-1:0]  count,
    output logic [NUM_T-1:0] decode
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (!hold && inc) begin
            count <= count + 1'b1;
        end
    end

    assign decode = onehot(count);
endmodule

// File: rtl/timing_sequencer.sv
// rtl/timing_sequencer.sv - SC, decode registers, S/IEN/R flip-flops and T/RT/D term generation
module timing_sequencer
    import basic_computer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    timing_sequencer_if.slave  bus
);
    logic             s;
    logic             r;
    logic             ien_q;
    logic             i_q;
    logic             d_valid;
    logic             d_on;
    logic             sc_err_q;
    logic [OPC_W-1:0] d_q;
    logic [11:0]      b_q;

    logic [SC_W-1:0]  sc;
    logic [NUM_T-1:0] sc_dec;
    logic [NUM_T-1:0] t;
    logic [2:0]       rt;
    logic [7:0]       d;
    logic             halt_now;
    logic             end_instr;
    logic             sc_clr;
    logic             irq_set;
    logic             ion_cyc;

    seq_counter u_sc (
        .clk    (clk),
        .rst    (rst),
        .clr    (sc_clr),
        .inc    (1'b1),
        .hold   (~s),
        .count  (sc),
        .decode (sc_dec)
    );

    // The interrupt cycle borrows SC values 0..2, so T0..T2 are masked while R is set.
    always_comb begin
        t = '0;
        for (int k = 0; k < NUM_T; k++) begin
            t[k] = s & sc_dec[k] & ~(r & (k < 3));
        end
        rt = {3{s & r}} & sc_dec[2:0];
    end

    assign d_on = d_valid;
    assign d    = d_on ? onehot(d_q) : '0;

    assign halt_now  = bus.hlt & d[OPC_REG] & ~i_q & t[3];
    assign ion_cyc   = d[OPC_REG] & i_q & t[3];
    assign end_instr = (d[OPC_REG] & t[3])
                     | ((d[OPC_STA] | d[OPC_BUN]) & t[4])
                     | ((d[OPC_AND] | d[OPC_ADD] | d[OPC_LDA] | d[OPC_BSA]) & t[5])
                     | (d[OPC_ISZ] & t[6])
                     | rt[2]
                     | t[7];
    assign sc_clr    = halt_now | end_instr;
    assign irq_set   = s & ~r & ien_q & (bus.fgi | bus.fgo) & (sc >= SC_W'(3));

    always_ff @(posedge clk) begin
        if (rst) begin
            s        <= 1'b1;
            r        <= 1'b0;
            ien_q    <= 1'b0;
            d_q      <= '0;
            i_q      <= 1'b0;
            b_q      <= '0;
            d_valid  <= 1'b0;
            sc_err_q <= 1'b0;
        end else begin
            if (halt_now) begin
                s <= 1'b0;
            end else if (!s && bus.start) begin
                s <= 1'b1;
            end

            if (rt[2]) begin
                r <= 1'b0;
            end else if (irq_set) begin
                r <= 1'b1;
            end

            // IOF outranks ION when an instruction sets both bits.
            if (rt[2]) begin
                ien_q <= 1'b0;
            end else if (ion_cyc && b_q[B_IOF]) begin
                ien_q <= 1'b0;
            end else if (ion_cyc && b_q[B_ION]) begin
                ien_q <= 1'b1;
            end

            if (t[2]) begin
                d_q     <= bus.ir[IR_OPC_HI:IR_OPC_LO];
                i_q     <= bus.ir[IR_I];
                b_q     <= bus.ir[11:0];
                d_valid <= 1'b1;
            end

            if (t[7]) begin
                sc_err_q <= 1'b1;
            end
        end
    end

    assign bus.T      = t;
    assign bus.RT     = rt;
    assign bus.D      = d;
    assign bus.I      = i_q;
    assign bus.In     = ~i_q;
    assign bus.D7n    = ~d[OPC_REG];
    assign bus.B      = b_q;
    assign bus.ien    = ien_q;
    assign bus.halted = ~s;
    assign bus.sc_err = sc_err_q;
endmodule

// File: tb/tb_timing_sequencer.sv
// tb/tb_timing_sequencer.sv - scoreboard bench for timing_sequencer with directed instruction vectors
module tb_timing_sequencer;
    logic clk = 1'b0;
    logic rst;

    timing_sequencer_if bus ();

    timing_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  t;
        logic [2:0]  rt;
        logic [7:0]  d;
        logic        i;
        logic [11:0] b;
        logic        ien;
        logic        halted;
        logic        err;
        string       tag;
    } exp_t;

    exp_t q[$];
    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  e_d   = 8'h00;
    logic        e_i   = 1'b0;
    logic [11:0] e_b   = 12'h000;
    logic        e_ien = 1'b0;
    logic        e_err = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] t, input logic [2:0] rt, input logic h, input string tag);
        exp_t e;
        e.t = t; e.rt = rt; e.d = e_d; e.i = e_i; e.b = e_b;
        e.ien = e_ien; e.halted = h; e.err = e_err; e.tag = tag;
        q.push_back(e);
    endtask

    // Runs one instruction from its T0 for len cycles; *_k selects the cycle whose closing edge sees that input.
    task automatic run_instr(input logic [15:0] iv, input int len, input logic [7:0] dexp,
                             input int fgi_k, input int fgo_k, input int hlt_k, input int start_k,
                             input string tag);
        logic [7:0] one = 8'h01;
        for (int k = 0; k < len; k++) begin
            if (k == 3) begin
                e_d = dexp; e_i = iv[15]; e_b = iv[11:0];
            end
            push(one << k, 3'b000, 1'b0, tag);
            if (k == 0) bus.ir = iv;
            if (k == fgi_k) bus.fgi = 1'b1;
            if (k == fgo_k) bus.fgo = 1'b1;
            bus.hlt   = (k == hlt_k);
            bus.start = (k == start_k);
            tick();
            if (k == 3 && dexp == 8'h80 && iv[15]) begin
                if (iv[6]) e_ien = 1'b0;
                else if (iv[7]) e_ien = 1'b1;
            end
        end
        bus.hlt   = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic run_rt_cycle(input string tag);
        logic [2:0] one = 3'b001;
        for (int k = 0; k < 3; k++) begin
            push(8'h00, one << k, 1'b0, tag);
            tick();
        end
        e_ien = 1'b0;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            if (bus.T !== e.t || bus.RT !== e.rt || bus.D !== e.d || bus.I !== e.i ||
                bus.B !== e.b || bus.ien !== e.ien || bus.halted !== e.halted ||
                bus.sc_err !== e.err || bus.In !== ~e.i || bus.D7n !== ~e.d[7]) begin
                miscompares++;
                $display("FAIL %s: got T=%h RT=%h D=%h I=%b In=%b D7n=%b B=%h ien=%b halted=%b sc_err=%b, expected T=%h RT=%h D=%h I=%b B=%h ien=%b halted=%b sc_err=%b",
                         e.tag, bus.T, bus.RT, bus.D, bus.I, bus.In, bus.D7n, bus.B, bus.ien,
                         bus.halted, bus.sc_err, e.t, e.rt, e.d, e.i, e.b, e.ien, e.halted, e.err);
            end
        end
    end

    initial begin
        logic [7:0] one = 8'h01;
        rst = 1'b1;
        bus.ir = 16'h0000; bus.hlt = 1'b0; bus.start = 1'b0; bus.fgi = 1'b0; bus.fgo = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        run_instr(16'h7800, 4, 8'h80, -1, -1, -1, -1, "cla");
        run_instr(16'h2123, 6, 8'h04, -1, -1, -1, 1, "lda_start_ignored");
        run_instr(16'hE123, 7, 8'h40, -1, -1, -1, -1, "isz_indirect");
        run_instr(16'h4010, 5, 8'h10, -1, -1, -1, -1, "bun");

        run_instr(16'h7001, 4, 8'h80, -1, -1, 3, -1, "hlt_instr");
        for (int k = 0; k < 10; k++) begin
            push(8'h00, 3'b000, 1'b1, "halted_hold");
            bus.start = (k == 9);
            tick();
        end
        bus.start = 1'b0;

        run_instr(16'hF080, 4, 8'h80, -1, -1, -1, -1, "ion");
        run_instr(16'h2123, 6, 8'h04, 4, -1, -1, -1, "lda_irq");
        bus.fgi = 1'b0;
        run_rt_cycle("irq_rt");

        run_instr(16'hF080, 4, 8'h80, -1, 3, -1, -1, "ion_fgo_same_t3");
        run_instr(16'h4010, 5, 8'h10, -1, -1, -1, -1, "bun_after_ion");
        bus.fgo = 1'b0;
        run_rt_cycle("overlap_rt");

        force dut.d_on = 1'b0;
        e_d = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                e_i = 1'b0; e_b = 12'h123;
            end
            push(one << k, 3'b000, 1'b0, "overflow_t7");
            if (k == 0) bus.ir = 16'h2123;
            tick();
        end
        release dut.d_on;
        e_d = 8'h04; e_err = 1'b1;
        run_instr(16'h7800, 4, 8'h80, -1, -1, -1, -1, "cla_after_overflow");

        run_instr(16'hF080, 4, 8'h80, -1, -1, -1, -1, "ion_before_rst");
        for (int k = 0; k < 5; k++) begin
            if (k == 3) begin
                e_d = 8'h40; e_i = 1'b1; e_b = 12'h123;
            end
            push(one << k, 3'b000, 1'b0, "isz_before_rst");
            if (k == 0) bus.ir = 16'hE123;
            if (k == 3) bus.fgi = 1'b1;
            if (k == 4) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        bus.fgi = 1'b0;
        e_d = 8'h00; e_i = 1'b0; e_b = 12'h000; e_ien = 1'b0; e_err = 1'b0;
        run_instr(16'h7800, 4, 8'h80, -1, -1, -1, -1, "cla_after_rst");

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expected vectors left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
